// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared definitions for the EX-stage ALU with multiply/divide.
//   - ALUOp encodings (combinational ops 0..15, HI/LO and MD ops 16..21)
//   - md_state_e: state type of the multiply/divide sequencer
//   - is_md_op / is_signed_md: op-class helpers
package alu_md_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_NOR   = 5'd6;
  localparam logic [4:0] OP_SLT   = 5'd7;
  localparam logic [4:0] OP_SLTU  = 5'd8;
  localparam logic [4:0] OP_SLL   = 5'd9;
  localparam logic [4:0] OP_SRL   = 5'd10;
  localparam logic [4:0] OP_SRA   = 5'd11;
  localparam logic [4:0] OP_PASSB = 5'd12;
  localparam logic [4:0] OP_LUI   = 5'd13;
  localparam logic [4:0] OP_MFHI  = 5'd14;
  localparam logic [4:0] OP_MFLO  = 5'd15;
  localparam logic [4:0] OP_MTHI  = 5'd16;
  localparam logic [4:0] OP_MTLO  = 5'd17;
  localparam logic [4:0] OP_MULT  = 5'd18;
  localparam logic [4:0] OP_MULTU = 5'd19;
  localparam logic [4:0] OP_DIV   = 5'd20;
  localparam logic [4:0] OP_DIVU  = 5'd21;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_md(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_md_if.sv
// alu_md_if: operand/opcode bus and result/flag bus of the EX-stage ALU.
//   master: drives A, B, ALUOp, start; observes C, flags, busy, hi, lo
//   slave : the ALU side
interface alu_md_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       ALUOp;
  logic             start;
  logic [WIDTH-1:0] C;
  logic             N;
  logic             Z;
  logic             V;
  logic             Carry;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output A, B, ALUOp, start,
                  input  C, N, Z, V, Carry, busy, hi, lo);
  modport slave  (input  A, B, ALUOp, start,
                  output C, N, Z, V, Carry, busy, hi, lo);
endinterface

// File: rtl/alu_md_md_unit.sv
// md_unit: iterative multiply/divide with HI/LO registers.
//   clk, reset (async, active-high)
//   a, b, op, start : operands, opcode and request qualifier
//   busy            : high for exactly WIDTH cycles per mult/div
//   hi, lo          : HI/LO registers
//
// state  | meaning
// S_IDLE | waiting; accepts mthi/mtlo or latches a mult/div request
// S_RUN  | one shift-add / shift-subtract step per cycle, cnt counts down
module md_unit
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, prod_fix;
  logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic               div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic               sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH:0]   div_sh;

  // One iteration of the datapath. Multiply shifts the accumulator right with
  // the carry of the partial sum; divide shifts left and keeps the trial
  // difference when it is non-negative (restoring division).
  always_comb begin
    sa       = is_signed_md(op) & a[WIDTH-1];
    sb       = is_signed_md(op) & b[WIDTH-1];
    a_mag    = sa ? -a : a;
    b_mag    = sb ? -b : b;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q, 1'b0};
    div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    if (div_q)
      step = div_diff[WIDTH] ? div_sh[2*WIDTH-1:0]
                             : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      step = {mul_sum, acc_q[WIDTH-1:1]};
    prod_fix = qneg_q ? -step : step;
    q_fix    = qneg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    r_fix    = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end else if (is_md_op(op)) begin
            state_d = S_RUN;
            cnt_d   = CNT_W'(WIDTH);
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            opnd_d  = b_mag;
            div_d   = (op == OP_DIV) || (op == OP_DIVU);
            // Divide by zero leaves the quotient as all ones; the remainder
            // correction still restores the original dividend.
            qneg_d  = (sa ^ sb) & ~(div_d & (b == '0));
            rneg_d  = sa;
          end
        end
      end
      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (div_q) begin
            hi_d = r_fix;
            lo_d = q_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_md.sv
// alu_md: EX-stage ALU. Combinational arithmetic/logic/shift result on C with
// N/Z/V/Carry flags, plus the md_unit for mult/div and HI/LO access.
//   clk, reset : clock and async active-high reset (md_unit only)
//   bus        : alu_md_if slave (A, B, ALUOp, start in; C, flags, busy, hi, lo out)
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  alu_md_if.slave    bus
);
  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]  shamt;
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic [WIDTH-1:0] c;
  logic             v, carry;

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .reset (reset),
    .a     (bus.A),
    .b     (bus.B),
    .op    (bus.ALUOp),
    .start (bus.start),
    .busy  (bus.busy),
    .hi    (bus.hi),
    .lo    (bus.lo)
  );

  assign shamt = bus.A[SH_W-1:0];

  always_comb begin
    c       = '0;
    v       = 1'b0;
    carry   = 1'b0;
    sum_ext = {1'b0, bus.A} + {1'b0, bus.B};
    dif_ext = {1'b0, bus.A} - {1'b0, bus.B};
    case (bus.ALUOp)
      OP_ADD: begin
        c     = sum_ext[WIDTH-1:0];
        carry = sum_ext[WIDTH];
        v     = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (c[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        c     = dif_ext[WIDTH-1:0];
        carry = dif_ext[WIDTH];
        v     = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (c[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:   c = bus.A & bus.B;
      OP_OR:    c = bus.A | bus.B;
      OP_XOR:   c = bus.A ^ bus.B;
      OP_NOR:   c = ~(bus.A | bus.B);
      OP_SLT:   c = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU:  c = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_SLL:   c = bus.B << shamt;
      OP_SRL:   c = bus.B >> shamt;
      OP_SRA:   c = $signed(bus.B) >>> shamt;
      OP_PASSB: c = bus.B;
      OP_LUI:   c = {bus.B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI:  c = bus.hi;
      OP_MFLO:  c = bus.lo;
      default:  c = '0;
    endcase
  end

  assign bus.C     = c;
  assign bus.N     = c[WIDTH-1];
  assign bus.Z     = (c == '0);
  assign bus.V     = v;
  assign bus.Carry = carry;

endmodule
